// File: rtl/bt_uart_rx_gen.sv
// Parametrised UART receiver: 3-sample majority vote, start-glitch rejection,
// framing-error and break reporting. Parity checking is added by UART_RX_PARITY_EN.
module bt_uart_rx_gen #(
    parameter int CLK_HZ    = 100000000,
    parameter int BAUD      = 2400,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX,
    output logic                 RX_vld,
    output logic [DATA_BITS-1:0] RXData,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BPS_S0    = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BPS_S2    = CW'(DIV / 2 + 1);
    localparam logic [CW-1:0] BPS_DEC   = CW'(DIV / 2 + 2);
    localparam logic [CW-1:0] BPS_LAST  = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rxs_q, rxs_dly_q;
    logic [CW-1:0]          bps_q, bps_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [2:0]             vote_q, vote_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   rxdata_q, rxdata_d;
    logic                   vld_q, vld_d;
    logic                   ferr_q, ferr_d;
    logic                   fall, maj, decide, bit_end;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    assign fall    = rxs_dly_q & ~rxs_q;
    assign maj     = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
    assign decide  = (bps_q == BPS_DEC);
    assign bit_end = (bps_q == BPS_LAST);

    always_comb begin
        state_d  = state_q;
        bps_d    = bit_end ? '0 : bps_q + CW'(1);
        bit_d    = bit_q;
        stop_d   = stop_q;
        vote_d   = vote_q;
        shreg_d  = shreg_q;
        rxdata_d = rxdata_q;
        vld_d    = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif
        if (bps_q >= BPS_S0 && bps_q <= BPS_S2) begin
            vote_d = {vote_q[1:0], rxs_q};
        end
        case (state_q)
            S_IDLE: begin
                bps_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                // A start bit that votes high was a glitch on the line.
                if (decide && maj) begin
                    state_d = S_IDLE;
                    bps_d   = '0;
                end else if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        stop_d = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (decide) par_d = maj;
                if (bit_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
`endif
            S_STOP: begin
                // Leave at the decision point so a back-to-back start is not missed.
                if (decide && !maj) begin
                    ferr_d  = 1'b1;
                    state_d = (shreg_q == '0) ? S_BREAK : S_IDLE;
                    bps_d   = '0;
                end else if (decide && stop_q == STOP_LAST) begin
                    state_d = S_IDLE;
                    bps_d   = '0;
`ifdef UART_RX_PARITY_EN
                    if (((^shreg_q) ^ par_q) != PARITY_ODD) begin
                        perr_d = 1'b1;
                    end else begin
                        vld_d    = 1'b1;
                        rxdata_d = shreg_q;
                    end
`else
                    vld_d    = 1'b1;
                    rxdata_d = shreg_q;
`endif
                end else if (bit_end) begin
                    stop_d = 1'b1;
                end
            end
            S_BREAK: begin
                bps_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                bps_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            rxs_dly_q <= 1'b1;
            state_q   <= S_IDLE;
            bps_q     <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            vote_q    <= '0;
            shreg_q   <= '0;
            rxdata_q  <= '0;
            vld_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RX;
            rxs_q     <= rx_meta_q;
            rxs_dly_q <= rxs_q;
            state_q   <= state_d;
            bps_q     <= bps_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            vote_q    <= vote_d;
            shreg_q   <= shreg_d;
            rxdata_q  <= rxdata_d;
            vld_q     <= vld_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign RX_vld    = vld_q;
    assign RXData    = rxdata_q;
    assign frame_err = ferr_q;
    assign break_det = (state_q == S_BREAK);
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_bt_uart_rx_gen.sv
// Bench for bt_uart_rx_gen: an 8N1 instance and a 7-bit/2-stop instance on a
// 16-clocks-per-bit line, checked against a frame-level event model.
module tb_bt_uart_rx_gen;
    localparam int DIV = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       vld_a, ferr_a, brk_a, busy_a, perr_a;
    logic [7:0] data_a;
    logic       vld_b, ferr_b, brk_b, busy_b, perr_b;
    logic [6:0] data_b;

    int n_chk = 0;
    int n_pass = 0;
    int excl_err = 0;

    // Event word: {kind, payload}; kind 0 = good frame, 1 = framing error, 2 = parity error.
    logic [10:0] exp_a[$], obs_a[$], exp_b[$], obs_b[$];
    logic [7:0]  last_good_a = 8'h00;
    logic [6:0]  last_good_b = 7'h00;
    logic [8:0]  d;
    logic        sh;
    bit          g;
    int          t;
`ifdef UART_RX_PARITY_EN
    logic        par_flip = 1'b0;
`endif

    typedef struct {
        logic [8:0] data;
        logic       stop_hi;
        bit         glitch;
        logic       exp_vld;
        logic       exp_ferr;
        logic [7:0] exp_rxdata;
    } vec_t;
    vec_t tab[6];

    bt_uart_rx_gen #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .RST(RST), .RX(rx_a), .RX_vld(vld_a), .RXData(data_a),
        .frame_err(ferr_a), .break_det(brk_a), .busy(busy_a)
`ifdef UART_RX_PARITY_EN
        , .parity_err(perr_a)
`endif
    );

    bt_uart_rx_gen #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .RST(RST), .RX(rx_b), .RX_vld(vld_b), .RXData(data_b),
        .frame_err(ferr_b), .break_det(brk_b), .busy(busy_b)
`ifdef UART_RX_PARITY_EN
        , .parity_err(perr_b)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign perr_a = 1'b0;
    assign perr_b = 1'b0;
`endif

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    always @(negedge CLK) begin
        if (vld_a === 1'b1)  obs_a.push_back({2'd0, 1'b0, data_a});
        if (ferr_a === 1'b1) obs_a.push_back({2'd1, 9'd0});
        if (perr_a === 1'b1) obs_a.push_back({2'd2, 9'd0});
        if (vld_b === 1'b1)  obs_b.push_back({2'd0, 2'b0, data_b});
        if (ferr_b === 1'b1) obs_b.push_back({2'd1, 9'd0});
        if (perr_b === 1'b1) obs_b.push_back({2'd2, 9'd0});
        if ((vld_a === 1'b1) + (ferr_a === 1'b1) + (perr_a === 1'b1) > 1) excl_err++;
        if ((vld_b === 1'b1) + (ferr_b === 1'b1) + (perr_b === 1'b1) > 1) excl_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_b = v;
    endtask

    // One bit period; the glitch flips the line for the clock caught by the middle vote sample.
    task automatic drive_bit(input int sel, input logic v, input bit glitch);
        for (int i = 0; i < DIV; i++) begin
            set_rx(sel, (glitch && i == 9) ? ~v : v);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input logic stop_hi, input bit glitch);
        int nb;
        int ns;
        logic [8:0] dd;
        nb = (sel == 0) ? 8 : 7;
        ns = (sel == 0) ? 1 : 2;
        dd = data;
        drive_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(sel, dd[i], glitch);
`ifdef UART_RX_PARITY_EN
        drive_bit(sel, (^dd) ^ par_flip, glitch);
`endif
        drive_bit(sel, stop_hi, 1'b0);
        for (int i = 1; i < ns; i++) drive_bit(sel, 1'b1, 1'b0);
    endtask

    task automatic gap(input int sel);
        drive_bit(sel, 1'b1, 1'b0);
        drive_bit(sel, 1'b1, 1'b0);
    endtask

    // Frame-level model: a low stop bit is a framing error, else the payload is delivered.
    task automatic model_frame(input int sel, input logic [8:0] data, input logic stop_hi);
        if (sel == 0) begin
            if (!stop_hi) exp_a.push_back({2'd1, 9'd0});
            else begin
                exp_a.push_back({2'd0, data});
                last_good_a = data[7:0];
            end
        end else begin
            if (!stop_hi) exp_b.push_back({2'd1, 9'd0});
            else begin
                exp_b.push_back({2'd0, data});
                last_good_b = data[6:0];
            end
        end
    endtask

    task automatic drain(input int sel, input string name);
        int tt;
        int n_exp;
        int n_obs;
        logic [10:0] e;
        logic [10:0] o;
        tt = 0;
        n_exp = (sel == 0) ? exp_a.size() : exp_b.size();
        n_obs = (sel == 0) ? obs_a.size() : obs_b.size();
        while (tt < 64 && n_obs < n_exp) begin
            @(posedge CLK);
            #1;
            tt++;
            n_obs = (sel == 0) ? obs_a.size() : obs_b.size();
        end
        repeat (4) @(posedge CLK);
        #1;
        n_obs = (sel == 0) ? obs_a.size() : obs_b.size();
        check({name, " event count"}, n_obs, n_exp);
        for (int k = 0; k < n_exp; k++) begin
            o = '1;
            if (sel == 0) begin
                e = exp_a.pop_front();
                if (obs_a.size() > 0) o = obs_a.pop_front();
            end else begin
                e = exp_b.pop_front();
                if (obs_b.size() > 0) o = obs_b.pop_front();
            end
            check({name, " event"}, o, e);
        end
        if (sel == 0) obs_a.delete();
        else obs_b.delete();
    endtask

    initial begin
        tab[0] = '{9'h0A5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        tab[1] = '{9'h03C, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tab[2] = '{9'h0FF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
        tab[3] = '{9'h001, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01};
        tab[4] = '{9'h080, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80};
        tab[5] = '{9'h0C3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset RX_vld a", vld_a, 0);
        check("reset frame_err a", ferr_a, 0);
        check("reset break_det a", brk_a, 0);
        check("reset busy a", busy_a, 0);
        check("reset RXData a", data_a, 0);
        check("reset busy b", busy_b, 0);
        check("reset RXData b", data_b, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;

        for (int i = 0; i < 6; i++) begin
            send_frame(0, tab[i].data, tab[i].stop_hi, tab[i].glitch);
            gap(0);
            if (tab[i].exp_vld)  exp_a.push_back({2'd0, tab[i].data});
            if (tab[i].exp_ferr) exp_a.push_back({2'd1, 9'd0});
            drain(0, "table");
            check("table RXData", data_a, tab[i].exp_rxdata);
            check("table busy idle", busy_a, 0);
        end
        last_good_a = 8'h80;
        check("no break after table", brk_a, 0);

        // Short low pulse: start bit rejected as a glitch.
        rx_a = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        rx_a = 1'b1;
        @(negedge CLK);
        check("glitch busy rises", busy_a, 1);
        t = 0;
        while (busy_a && t < DIV) begin @(negedge CLK); t++; end
        check("glitch busy drops", busy_a, 0);
        drain(0, "glitch");

        // Line low for two frame times: framing error, then break held until release.
        rx_a = 1'b0;
        repeat (2 * 10 * DIV) begin @(posedge CLK); #1; end
        @(negedge CLK);
        check("break_det held", brk_a, 1);
        check("busy in break", busy_a, 1);
        rx_a = 1'b1;
        t = 0;
        while (brk_a && t < 8) begin @(negedge CLK); t++; end
        check("break_det cleared", brk_a, 0);
        exp_a.push_back({2'd1, 9'd0});
        drain(0, "break");
        check("break RXData kept", data_a, last_good_a);

        for (int n = 0; n < 10; n++) begin
            d = 9'($urandom_range(0, 255));
            sh = ($urandom_range(0, 5) != 0);
            g = bit'($urandom_range(0, 1));
            send_frame(0, d, sh, g);
            gap(0);
            model_frame(0, d, sh);
            drain(0, "rand a");
            check("rand a RXData", data_a, last_good_a);
        end

        // Back-to-back 7-bit / 2-stop frames with mid-sample glitches.
        send_frame(1, 9'h041, 1'b1, 1'b1);
        send_frame(1, 9'h07F, 1'b1, 1'b1);
        gap(1);
        model_frame(1, 9'h041, 1'b1);
        model_frame(1, 9'h07F, 1'b1);
        drain(1, "b2b");
        check("b2b RXData", data_b, 7'h7F);

        for (int n = 0; n < 3; n++) begin
            for (int m = 0; m < 3; m++) begin
                d = 9'($urandom_range(0, 127));
                g = bit'($urandom_range(0, 1));
                send_frame(1, d, 1'b1, g);
                model_frame(1, d, 1'b1);
            end
            gap(1);
            drain(1, "rand b");
            check("rand b RXData", data_b, last_good_b);
        end

`ifdef UART_RX_PARITY_EN
        send_frame(0, 9'h055, 1'b1, 1'b0);
        gap(0);
        model_frame(0, 9'h055, 1'b1);
        drain(0, "parity good");
        par_flip = 1'b1;
        send_frame(0, 9'h066, 1'b1, 1'b0);
        gap(0);
        par_flip = 1'b0;
        exp_a.push_back({2'd2, 9'd0});
        drain(0, "parity bad");
        check("parity RXData kept", data_a, 8'h55);
        last_good_a = 8'h55;
`endif

        // Reset during data bit 4; the rest of the frame holds the line high.
        fork
            send_frame(0, 9'h0F3, 1'b1, 1'b0);
            begin
                repeat (5 * DIV + 8) @(posedge CLK);
                #1;
                RST = 1'b1;
                @(posedge CLK);
                @(negedge CLK);
                check("midreset RX_vld", vld_a, 0);
                check("midreset frame_err", ferr_a, 0);
                check("midreset break_det", brk_a, 0);
                check("midreset busy", busy_a, 0);
                check("midreset RXData a", data_a, 0);
                check("midreset RXData b", data_b, 0);
                @(posedge CLK);
                #1;
                RST = 1'b0;
            end
        join
        last_good_a = 8'h00;
        last_good_b = 7'h00;
        gap(0);
        drain(0, "midreset");
        send_frame(0, 9'h012, 1'b1, 1'b0);
        gap(0);
        model_frame(0, 9'h012, 1'b1);
        drain(0, "after reset");
        check("after reset RXData", data_a, 8'h12);

        check("pulse exclusivity", excl_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
